mem_pattern_tester: RTL and testbench

MEM_PATTERN_TESTER -- requirements
Module: mem_pattern_tester

---
 rtl/mem_pattern_tester_if.sv | 31 +++
 rtl/mem_pattern_tester.sv | 191 +++++++++++++++++++
 tb/tb_mem_pattern_tester.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pattern_tester_if.sv
// Memory-side bus between the pattern tester (master) and a single-port
// synchronous RAM (slave).
//   address    : word address, ADDR_W bits
//   byteenable : per-byte write enable, DATA_W/8 bits
//   chipselect : access strobe
//   write      : 1 = write access, 0 = read access
//   writedata  : data for write accesses
//   clken      : RAM clock enable
//   readdata   : RAM read data, valid one cycle after the address
interface mem_pattern_tester_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                clken;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/mem_pattern_tester.sv
// Memory pattern tester: writes seed+i to len consecutive words starting at
// base (address wraps modulo 2^ADDR_W), reads them back, and counts mismatches.
//
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   start                 : one-cycle test request, honoured only in IDLE
//   base, len, seed       : test region start, word count (clamped to
//                           2^ADDR_W), pattern seed
//   mem                   : memory bus (master modport)
//   busy, done            : busy outside IDLE; done is a one-cycle pulse
//   error, err_count      : sticky mismatch flag and saturating count
//   first_err_addr/_data  : address and observed data of the first mismatch
//
// Build option: define MEM_TESTER_ERRLOG_EN to keep the first-error log;
// without it the log outputs are tied to zero and have no registers.
module mem_pattern_tester #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base,
  input  logic [ADDR_W:0]      len,
  input  logic [DATA_W-1:0]    seed,
  mem_pattern_tester_if.master mem,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [15:0]          err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [DATA_W-1:0]    first_err_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   IDX_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [DATA_W-1:0] DATA_ONE = 1;

  logic [2:0]        state_reg;
  logic [ADDR_W:0]   idx_reg;      // 1-based index of the word on the bus
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [DATA_W-1:0] seed_reg;
  logic [ADDR_W-1:0] address_reg;
  logic [DATA_W-1:0] writedata_reg; // current pattern word in both phases
  logic              chipselect_reg;
  logic              write_reg;
  logic              cmp_valid_reg; // readdata this cycle belongs to a read
  logic [DATA_W-1:0] cmp_exp_reg;
  logic              error_reg;
  logic [15:0]       err_count_reg;

  logic [ADDR_W:0] len_clamped;
  logic            mismatch;

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign mismatch    = cmp_valid_reg && (mem.readdata != cmp_exp_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      idx_reg        <= '0;
      len_reg        <= '0;
      base_reg       <= '0;
      seed_reg       <= '0;
      address_reg    <= '0;
      writedata_reg  <= '0;
      chipselect_reg <= 1'b0;
      write_reg      <= 1'b0;
      cmp_valid_reg  <= 1'b0;
      cmp_exp_reg    <= '0;
      error_reg      <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      cmp_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            base_reg      <= base;
            seed_reg      <= seed;
            len_reg       <= len_clamped;
            error_reg     <= 1'b0;
            err_count_reg <= '0;
            if (len_clamped == '0) begin
              state_reg <= S_DONE;
            end else begin
              // Bus registers are loaded together with the state so the
              // first write is on the bus in the first WRITE cycle.
              state_reg      <= S_WRITE;
              address_reg    <= base;
              writedata_reg  <= seed;
              chipselect_reg <= 1'b1;
              write_reg      <= 1'b1;
              idx_reg        <= IDX_ONE;
            end
          end
        end
        S_WRITE: begin
          if (idx_reg == len_reg) begin
            state_reg     <= S_READ;
            address_reg   <= base_reg;
            writedata_reg <= seed_reg;
            write_reg     <= 1'b0;
            idx_reg       <= IDX_ONE;
          end else begin
            address_reg   <= address_reg + ADDR_ONE;
            writedata_reg <= writedata_reg + DATA_ONE;
            idx_reg       <= idx_reg + IDX_ONE;
          end
        end
        S_READ: begin
          // The RAM answers one cycle later, so the expected word travels
          // one stage behind the address.
          cmp_valid_reg <= 1'b1;
          cmp_exp_reg   <= writedata_reg;
          if (idx_reg == len_reg) begin
            state_reg      <= S_DRAIN;
            chipselect_reg <= 1'b0;
          end else begin
            address_reg   <= address_reg + ADDR_ONE;
            writedata_reg <= writedata_reg + DATA_ONE;
            idx_reg       <= idx_reg + IDX_ONE;
          end
        end
        S_DRAIN: state_reg <= S_DONE;
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase

      // A compare is never pending in IDLE, so this cannot collide with
      // the clear on start.
      if (mismatch) begin
        error_reg <= 1'b1;
        if (err_count_reg != 16'hFFFF) begin
          err_count_reg <= err_count_reg + 16'd1;
        end
      end
    end
  end

`ifdef MEM_TESTER_ERRLOG_EN
  logic [ADDR_W-1:0] cmp_addr_reg;
  logic [ADDR_W-1:0] first_err_addr_reg;
  logic [DATA_W-1:0] first_err_data_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_addr_reg       <= '0;
      first_err_addr_reg <= '0;
      first_err_data_reg <= '0;
    end else begin
      if (state_reg == S_READ) begin
        cmp_addr_reg <= address_reg;
      end
      if (state_reg == S_IDLE && start) begin
        first_err_addr_reg <= '0;
        first_err_data_reg <= '0;
      end else if (mismatch && !error_reg) begin
        first_err_addr_reg <= cmp_addr_reg;
        first_err_data_reg <= mem.readdata;
      end
    end
  end

  assign first_err_addr = first_err_addr_reg;
  assign first_err_data = first_err_data_reg;
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

  assign mem.address    = address_reg;
  assign mem.writedata  = writedata_reg;
  assign mem.chipselect = chipselect_reg;
  assign mem.write      = write_reg;
  assign mem.byteenable = '1;
  assign mem.clken      = 1'b1;

  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign error     = error_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_mem_pattern_tester.sv
module tb_mem_pattern_tester;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] seed = '0;
  logic          busy, done, error;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_data;

  mem_pattern_tester_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_pattern_tester #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base           (base),
    .len            (len),
    .seed           (seed),
    .mem            (bus.master),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Ideal 1-cycle RAM with an optional corrupted word on the read path.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  always @(posedge clk) begin
    if (bus.chipselect && bus.write) ram[bus.address] <= bus.writedata;
    if (bus.chipselect && !bus.write)
      bus.readdata <= ram[bus.address] ^ ((corrupt_en && bus.address == corrupt_addr) ? 32'h1 : 32'h0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Test model: expected bus/status trace as a function of the cycle
  // offset k after the start edge (k=1 is the first cycle after it).
  logic    model_active = 1'b0;
  logic    check_en = 1'b0;
  int      m_t0, m_base, m_n;
  logic [DW-1:0] m_seed;
  int      done_k, busy_cycles;
  logic [AW-1:0] addr_log[$];

  always @(negedge clk) begin : compare
    int k;
    logic e_cs, e_wr, e_busy, e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    e_cs = 0; e_wr = 0; e_busy = 0; e_done = 0; e_addr = '0; e_data = '0;
    k = cycle - m_t0 + 1;
    if (model_active) begin
      if (m_n == 0) begin
        if (k == 1) begin e_busy = 1; e_done = 1; end
      end else if (k >= 1 && k <= m_n) begin
        e_cs = 1; e_wr = 1; e_busy = 1;
        e_addr = AW'(m_base + k - 1);
        e_data = m_seed + DW'(k - 1);
      end else if (k > m_n && k <= 2*m_n) begin
        e_cs = 1; e_busy = 1;
        e_addr = AW'(m_base + k - m_n - 1);
      end else if (k == 2*m_n + 1) begin
        e_busy = 1;
      end else if (k == 2*m_n + 2) begin
        e_busy = 1; e_done = 1;
      end
    end
    if (check_en) begin
      chk("cs_wr", {62'd0, bus.chipselect, bus.write}, {62'd0, e_cs, e_wr});
      if (e_cs) chk("address", 64'(bus.address), 64'(e_addr));
      if (e_wr) chk("writedata", 64'(bus.writedata), 64'(e_data));
      chk("busy_done", {62'd0, busy, done}, {62'd0, e_busy, e_done});
      chk("be_clken", {55'd0, bus.byteenable, bus.clken}, {55'd0, 4'hF, 1'b1});
      if (model_active && done) done_k = k;
      if (model_active && busy) busy_cycles++;
      if (model_active && bus.chipselect) addr_log.push_back(bus.address);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic begin_test(input logic [AW-1:0] b, input logic [AW:0] l, input logic [DW-1:0] s);
    base = b; len = l; seed = s; start = 1'b1;
    tick();
    start = 1'b0;
    m_t0 = cycle; m_base = int'(b); m_n = (l > 1024) ? 1024 : int'(l); m_seed = s;
    done_k = -1; busy_cycles = 0; addr_log.delete();
    model_active = 1'b1;
  endtask

  task automatic run(input logic [AW-1:0] b, input logic [AW:0] l, input logic [DW-1:0] s);
    begin_test(b, l, s);
    repeat (2*m_n + 3) @(negedge clk);
    tick();
    model_active = 1'b0;
    $display("test base=%h len=%0d seed=%h done_k=%0d error=%0b err_count=%0d",
             b, l, s, done_k, error, err_count);
  endtask

  initial begin : stim
    logic [AW-1:0] exp_wrap [8];
    exp_wrap = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h3FE, 10'h3FF, 10'h000, 10'h001};

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_address", 64'(bus.address), 64'h0);
    chk("rst_writedata", 64'(bus.writedata), 64'h0);
    chk("rst_status", {44'd0, busy, done, error, err_count}, 64'h0);
    chk("rst_log", {22'd0, first_err_addr, first_err_data}, 64'h0);

    // Basic 16-word run
    run(10'h000, 11'd16, 32'h1000_0000);
    chk("basic_done_k", 64'(done_k), 64'd34);
    chk("basic_err", {47'd0, error, err_count}, 64'h0);
    chk("basic_ram0", 64'(ram[0]), 64'h1000_0000);
    chk("basic_ram15", 64'(ram[15]), 64'h1000_000F);
    chk("basic_nacc", 64'(addr_log.size()), 64'd32);

    // Address wrap
    run(10'h3FE, 11'd4, 32'hDEAD_0000);
    chk("wrap_nacc", 64'(addr_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < addr_log.size(); i++)
      chk("wrap_addr", 64'(addr_log[i]), 64'(exp_wrap[i]));

    // Corrupted word 5
    corrupt_en = 1'b1; corrupt_addr = 10'd5;
    run(10'h000, 11'd8, 32'hA5A5_0000);
    corrupt_en = 1'b0;
    chk("corrupt_err", {47'd0, error, err_count}, {47'd0, 1'b1, 16'd1});
`ifdef MEM_TESTER_ERRLOG_EN
    chk("corrupt_log", {22'd0, first_err_addr, first_err_data}, {22'd0, 10'd5, 32'hA5A5_0004});
`else
    chk("corrupt_log", {22'd0, first_err_addr, first_err_data}, 64'h0);
`endif

    // Clean run clears sticky error and log
    run(10'h020, 11'd3, 32'h0000_FFFF);
    chk("clear_err", {47'd0, error, err_count}, 64'h0);
    chk("clear_log", {22'd0, first_err_addr, first_err_data}, 64'h0);

    // Zero length
    run(10'h007, 11'd0, 32'h1234_5678);
    chk("zero_done_k", 64'(done_k), 64'd1);
    chk("zero_busy", 64'(busy_cycles), 64'd1);
    chk("zero_nacc", 64'(addr_log.size()), 64'd0);

    // Start ignored while busy, then reset during READ word 3
    begin_test(10'h000, 11'd8, 32'h5555_0000);
    tick(); tick();                       // now in cycle k=3 (WRITE)
    base = 10'h100; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();                    // now in cycle k=12: READ word 3
    reset = 1'b1;
    tick();
    model_active = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_cs_busy", {62'd0, bus.chipselect, busy}, 64'h0);
    chk("midrst_bus", {22'd0, bus.address, bus.writedata}, 64'h0);
    $display("test mid-read reset busy=%0b chipselect=%0b", busy, bus.chipselect);

    // Reset wins over start in the same cycle
    tick();
    reset = 1'b1; start = 1'b1; len = 11'd4;
    tick();
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_over_start", {62'd0, busy, bus.chipselect}, 64'h0);
    tick();

    // Clamp: 2047 -> 1024 words
    run(10'h155, 11'd2047, 32'h0BAD_F00D);
    chk("clamp_done_k", 64'(done_k), 64'd2050);
    chk("clamp_nacc", 64'(addr_log.size()), 64'd2048);
    chk("clamp_err", {47'd0, error, err_count}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
